encdec_apb_ctrl: RTL and testbench

APB slave and operation sequencer directly upstream of the EncDec core and its golden-model checker. Holds the CTRL, DATA_IN, CODEWORD_WIDTH and NOISE registers and drives them to the core. Issues a one-cycle start pulse on every accepted CTRL write, then tracks the operation until the core returns operation_done. Guards against lost completions with a timeout counter.

---
 rtl/encdec_apb_ctrl.sv | 150 +++++++++++++++
 tb/tb_encdec_apb_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/encdec_apb_ctrl.sv
// APB register block and start/busy sequencer for the EncDec core.
// Writes are rejected while an operation is in flight and when the value is illegal.
module encdec_apb_ctrl #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [AMBA_WORD-1:0]       ctrl,
  output logic [AMBA_WORD-1:0]       data_in,
  output logic [AMBA_WORD-1:0]       codeword_width,
  output logic [AMBA_WORD-1:0]       noise,
  output logic                       start,
  output logic                       busy,
  input  logic                       operation_done
);

  // state | meaning
  // IDLE  | no operation, writes accepted
  // START | one-cycle start pulse to the core
  // BUSY  | waiting for operation_done or timeout
  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] A_CTRL  = 2'b00;
  localparam logic [1:0] A_DATA  = 2'b01;
  localparam logic [1:0] A_CW    = 2'b10;
  localparam logic [1:0] A_NOISE = 2'b11;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tflag_q, tflag_d;
  logic [AMBA_WORD-1:0] ctrl_q, ctrl_d, data_q, data_d, cw_q, cw_d, noise_q, noise_d;
  logic [AMBA_WORD-1:0] prdata_q, prdata_d;

  logic [1:0] addr;
  logic       wr_acc, rd_setup, reject, wr_ok;
  logic       unused_addr_bits;

  assign addr             = PADDR[3:2];
  assign unused_addr_bits = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};
  assign wr_acc           = PSEL & PENABLE & PWRITE;
  assign rd_setup         = PSEL & ~PENABLE & ~PWRITE;

  always_comb begin
    reject = (state_q != IDLE)
           || ((addr == A_CW)   && (PWDATA[1:0] == 2'b11))
           || ((addr == A_CTRL) && (PWDATA[1:0] == 2'b11));
  end

  assign wr_ok = wr_acc & ~reject;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tflag_d  = tflag_q;
    ctrl_d   = ctrl_q;
    data_d   = data_q;
    cw_d     = cw_q;
    noise_d  = noise_q;
    prdata_d = prdata_q;

    if (wr_ok) begin
      case (addr)
        A_CTRL:  ctrl_d  = PWDATA;
        A_DATA:  data_d  = PWDATA;
        A_CW:    cw_d    = PWDATA;
        default: noise_d = PWDATA;
      endcase
    end

    if (rd_setup) begin
      case (addr)
        A_CTRL:  prdata_d = {state_q != IDLE, tflag_q, ctrl_q[AMBA_WORD-3:0]};
        A_DATA:  prdata_d = data_q;
        A_CW:    prdata_d = cw_q;
        default: prdata_d = noise_q;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (wr_ok && (addr == A_CTRL)) begin
          state_d = START;
          tflag_d = 1'b0;
        end
      end
      START: begin
        state_d = BUSY;
        cnt_d   = '0;
      end
      BUSY: begin
        // A completion arriving on the last counted cycle takes priority over timeout.
        if (operation_done) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          tflag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tflag_q  <= 1'b0;
      ctrl_q   <= '0;
      data_q   <= '0;
      cw_q     <= '0;
      noise_q  <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tflag_q  <= tflag_d;
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      cw_q     <= cw_d;
      noise_q  <= noise_d;
      prdata_q <= prdata_d;
    end
  end

  assign PRDATA         = prdata_q;
  assign PREADY         = PSEL & PENABLE;
  assign PSLVERR        = wr_acc & reject;
  assign ctrl           = ctrl_q;
  assign data_in        = data_q;
  assign codeword_width = cw_q;
  assign noise          = noise_q;
  assign start          = (state_q == START);
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_encdec_apb_ctrl.sv
// Directed bench for encdec_apb_ctrl: register access, sequencing, lockout and timeout.
module tb_encdec_apb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [19:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] ctrl, data_in, codeword_width, noise;
  logic        start, busy;
  logic        operation_done = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  logic        err;
  logic [31:0] rd;
  int          nb;

  encdec_apb_ctrl dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .ctrl(ctrl), .data_in(data_in), .codeword_width(codeword_width), .noise(noise),
    .start(start), .busy(busy), .operation_done(operation_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic e);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {16'h0, a}; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    #1;
    e = PSLVERR;
    chk("pready_wr", {31'h0, PREADY}, 32'h1);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {16'h0, a};
    @(posedge clk); #1;
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    e = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pulse_done();
    operation_done = 1'b1;
    @(posedge clk); #1;
    operation_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_start", {31'h0, start}, 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    rst = 1'b0;

    // program and run
    apb_write(4'h4, 32'h0000_00A5, err); chk("wr_data_err", {31'h0, err}, 32'h0);
    apb_write(4'h8, 32'h0, err);         chk("wr_cw_err", {31'h0, err}, 32'h0);
    apb_write(4'hC, 32'h1, err);         chk("wr_noise_err", {31'h0, err}, 32'h0);
    chk("data_in_port", data_in, 32'hA5);
    chk("noise_port", noise, 32'h1);
    chk("start_before", {31'h0, start}, 32'h0);
    apb_write(4'h0, 32'h0, err);         chk("wr_ctrl_err", {31'h0, err}, 32'h0);
    chk("start_pulse", {31'h0, start}, 32'h1);
    chk("busy_start", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    chk("start_gone", {31'h0, start}, 32'h0);
    chk("busy_busy", {31'h0, busy}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    pulse_done();
    chk("busy_after_done", {31'h0, busy}, 32'h0);
    apb_read(4'h4, rd, err); chk("rd_data", rd, 32'hA5);
    apb_read(4'h8, rd, err); chk("rd_cw", rd, 32'h0);
    apb_read(4'hC, rd, err); chk("rd_noise", rd, 32'h1);
    apb_read(4'h0, rd, err); chk("rd_ctrl_idle", rd, 32'h0);

    // busy lockout
    apb_write(4'h0, 32'h1, err);
    apb_write(4'hC, 32'h3, err); chk("lock_err", {31'h0, err}, 32'h1);
    chk("lock_noise", noise, 32'h1);
    apb_read(4'h0, rd, err);
    chk("rd_ctrl_busy", rd, 32'h8000_0001);
    chk("rd_busy_err", {31'h0, err}, 32'h0);
    pulse_done();
    chk("lock_idle", {31'h0, busy}, 32'h0);
    apb_read(4'hC, rd, err); chk("rd_noise_lock", rd, 32'h1);

    // illegal values
    apb_write(4'h8, 32'h3, err); chk("cw_illegal_err", {31'h0, err}, 32'h1);
    apb_read(4'h8, rd, err);     chk("cw_unchanged", rd, 32'h0);
    apb_write(4'h8, 32'h2, err); chk("cw_legal_err", {31'h0, err}, 32'h0);
    chk("cw_port", codeword_width, 32'h2);
    apb_write(4'h0, 32'h3, err); chk("ctrl_illegal_err", {31'h0, err}, 32'h1);
    chk("ctrl_illegal_start", {31'h0, start}, 32'h0);
    chk("ctrl_illegal_busy", {31'h0, busy}, 32'h0);
    chk("ctrl_port", ctrl, 32'h1);

    // timeout
    apb_write(4'h0, 32'h1, err);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
      nb++;
    end
    chk("timeout_cycles", nb, 64);
    apb_read(4'h0, rd, err); chk("rd_ctrl_timeout", rd, 32'h4000_0001);
    apb_write(4'h0, 32'h2, err);
    apb_read(4'h0, rd, err); chk("rd_ctrl_flagclr", rd, 32'h8000_0002);
    pulse_done();

    // done on the last counted BUSY cycle
    apb_write(4'h0, 32'h0, err);
    repeat (64) @(posedge clk);
    #1;
    chk("coll_still_busy", {31'h0, busy}, 32'h1);
    pulse_done();
    chk("coll_idle", {31'h0, busy}, 32'h0);
    apb_read(4'h0, rd, err); chk("rd_ctrl_coll", rd, 32'h0);

    // asynchronous reset mid-BUSY
    apb_write(4'h4, 32'h5A, err);
    apb_write(4'h0, 32'h1, err);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_start", {31'h0, start}, 32'h0);
    chk("arst_ctrl", ctrl, 32'h0);
    chk("arst_data", data_in, 32'h0);
    chk("arst_cw", codeword_width, 32'h0);
    chk("arst_noise", noise, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    apb_read(4'h0, rd, err); chk("rd_ctrl_arst", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
